// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage: PC, I-cache read handshake, redirects and a 1-entry hold buffer
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] INSTRUCTION_OUT,
    output logic [31:0] PC_PLUS_4_OUT,
    output logic [31:0] PC_DIRECT_OUT,
    output logic        INSTR_VALID,
    output logic        FETCH_BUSYWAIT
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] hold_instr, hold_instr_nxt;
    logic [31:0] disc_addr, disc_addr_nxt;
    logic [31:0] branch_pc;
    logic        fetch_done;

    assign branch_pc  = BRANCH_TARGET & ~32'h0000_0003;
    assign fetch_done = !IMEM_BUSYWAIT;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            hold_instr <= NOP_INSTR;
            disc_addr  <= 32'h0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            hold_instr <= hold_instr_nxt;
            disc_addr  <= disc_addr_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        hold_instr_nxt  = hold_instr;
        disc_addr_nxt   = disc_addr;
        IMEM_READ       = 1'b0;
        IMEM_ADDRESS    = pc;
        INSTR_VALID     = 1'b0;
        INSTRUCTION_OUT = NOP_INSTR;

        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end

            S_FETCH: begin
                IMEM_READ = 1'b1;
                if (BRANCH_TAKEN) begin
                    pc_nxt = branch_pc;
                    // an in-flight miss must run to completion on its original address
                    if (IMEM_BUSYWAIT) begin
                        disc_addr_nxt = pc;
                        state_nxt     = S_DISCARD;
                    end
                end else if (fetch_done) begin
                    INSTR_VALID     = 1'b1;
                    INSTRUCTION_OUT = IMEM_READDATA;
                    if (STALL) begin
                        hold_instr_nxt = IMEM_READDATA;
                        state_nxt      = S_HOLD;
                    end else begin
                        pc_nxt = pc + 32'd4;
                    end
                end
            end

            S_HOLD: begin
                INSTR_VALID     = !BRANCH_TAKEN;
                INSTRUCTION_OUT = BRANCH_TAKEN ? NOP_INSTR : hold_instr;
                if (BRANCH_TAKEN) begin
                    pc_nxt         = branch_pc;
                    hold_instr_nxt = NOP_INSTR;
                    state_nxt      = S_FETCH;
                end else if (!STALL) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = S_FETCH;
                end
            end

            S_DISCARD: begin
                IMEM_READ    = 1'b1;
                IMEM_ADDRESS = disc_addr;
                if (BRANCH_TAKEN)
                    pc_nxt = branch_pc;
                if (fetch_done)
                    state_nxt = S_FETCH;
            end

            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    assign PC_DIRECT_OUT  = pc;
    assign PC_PLUS_4_OUT  = pc + 32'd4;
    assign FETCH_BUSYWAIT = !(INSTR_VALID && !STALL && !BRANCH_TAKEN);

endmodule
